inv_sub_bytes: RTL and testbench
================================

# inv_sub_bytes

Inverse AES SubBytes stage for the decryption datapath. Applies the inverse S-box to each byte of a 128-bit state, one byte per cycle through a single internal inverse S-box lookup. Sits after inverse ShiftRows in each decryption round and mirrors the encryption-side SubBytes stage: same byte-lane ordering, same 16-cycle serial cost, same `ready` semantics. Adds an explicit `start`/`busy` handshake so the round controller can sequence it.

## Interface
- No parameters. Lane count is fixed at build time by the macro under Configuration.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request. Sampled only in IDLE or DONE.
- `data_in`  input  128  state to transform. Captured on the `start` edge; not required to be held afterwards.
- `data_out`  output  128  transformed state. Registered and updated only at completion. Holds its value otherwise.
- `ready`  output  1  level. High from completion until the next accepted `start` or reset.
- `busy`  output  1  high while in RUN.

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN: 4-bit byte counter `cnt`.
  - DONE.
- IDLE/DONE with `start`=1 at an edge:
  - capture `data_in` into the work register;
  - `cnt`←0, state→RUN, `ready`←0.
- RUN, each edge:
  - byte lane `cnt` of the work register (bits 8·cnt+7 : 8·cnt) is replaced by InvSbox(that byte);
  - `cnt`←`cnt`+1.
  - Lanes are processed in order 0..15, least-significant byte first.
- RUN with `cnt`=15:
  - the final lane is written;
  - `data_out` is loaded with the full work register, including the lane-15 result from the same edge;
  - `ready`←1, state→DONE.
- DONE: `data_out` and `ready` hold. `start` behaves as in IDLE, so back-to-back operation is allowed with no idle cycle.
- `start` during RUN is ignored. No queuing; the work register is not disturbed.
- Inverse S-box: combinational 256-entry table inside this module, per FIPS-197 Figure 14. No GF(2^8) inversion logic.
- Reset (rst=0), at any time including mid-RUN:
  - state→IDLE, `cnt`←0;
  - `ready`←0, `busy`←0;
  - `data_out`←128'h0, work register←0.
  - Partial results are discarded. The next operation requires a fresh `start`.

## Timing
- Edge E0 accepts `start`.
- `busy`=1 after E0 through E16.
- Lane k is written at edge E(k+1).
- `data_out` is valid and `ready`=1 after E16. Latency from `start` edge to `ready` is 16 cycles.
- `busy` drops and `ready` rises on the same edge (E16). They are never both high.
- `data_out` never shows a partially transformed state.
- A restart from DONE at edge E0' drops `ready` after E0'. `data_out` keeps the previous result until the new completion.
- Reset deassertion is not synchronized internally. The parent supplies a synchronized deassertion.

## Configuration
- Macro: `INV_SUB_BYTES_QUAD_EN`.
- Undefined:
  - one inverse S-box instance;
  - 1 lane per cycle, 16-cycle latency as above.
- Defined:
  - four inverse S-box tables;
  - lanes 4j..4j+3 are written at edge E(j+1), j=0..3;
  - `cnt` advances by 4; completion at E4; latency 4 cycles.
  - Handshake, ordering, reset and DONE behaviour are unchanged.

## Test plan
- Reset, then `data_in`=128'h6363…63 (all 16 bytes 0x63) with one-cycle `start` -> `busy` high for 16 cycles; after E16 `data_out`=128'h0 and `ready`=1; `data_out`=0 at every earlier edge.
- Lane ordering: `data_in`=128'h5252…52ED (byte0=0xED, all other bytes 0x52) -> `data_out`=128'h4848…4853 (byte0=0x53, all other bytes 0x48).
- Table spot checks in successive runs, values placed in varying lanes:
  - 0x7C->0x01
  - 0x16->0xFF
  - 0x00->0x52
  - 0x8C->0xF0
- Full-table sweep: a model drives 16 runs covering all 256 byte values; every result must match the reference inverse table.
- `start` pulsed at E5 during RUN -> ignored; completion still at E16 with the original result. Then `start` held high in DONE -> restart on the next edge, `ready` drops, second result arrives 16 cycles later.
- Reset mid-run at cycle 8 -> `busy`, `ready`, `data_out` all 0 immediately (asynchronously). After release, no activity until `start`; a new run completes correctly.
- With `INV_SUB_BYTES_QUAD_EN` defined, repeat the first two scenarios -> same results with `ready` after E4.

Source files
------------

// File: rtl/inv_sub_bytes.sv
// Inverse AES SubBytes: serial inverse S-box over a 128-bit state, LSB lane first.
// Define INV_SUB_BYTES_QUAD_EN to process four lanes per cycle (4-cycle latency).
module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef INV_SUB_BYTES_QUAD_EN
    localparam logic [3:0] CNT_STEP = 4'd4;
    localparam logic [3:0] LAST_CNT = 4'd12;
`else
    localparam logic [3:0] CNT_STEP = 4'd1;
    localparam logic [3:0] LAST_CNT = 4'd15;
`endif

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   data_out_q, data_out_d;
    logic           ready_q, ready_d;
`ifdef INV_SUB_BYTES_QUAD_EN
    logic [31:0]    lane_word;
`endif

    // FIPS-197 inverse S-box as a plain lookup table
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        inv_sbox = 8'h00;
        case (b)
            8'h00: inv_sbox = 8'h52;
            8'h01: inv_sbox = 8'h09;
            8'h02: inv_sbox = 8'h6a;
            8'h03: inv_sbox = 8'hd5;
            8'h04: inv_sbox = 8'h30;
            8'h05: inv_sbox = 8'h36;
            8'h06: inv_sbox = 8'ha5;
            8'h07: inv_sbox = 8'h38;
            8'h08: inv_sbox = 8'hbf;
            8'h09: inv_sbox = 8'h40;
            8'h0a: inv_sbox = 8'ha3;
            8'h0b: inv_sbox = 8'h9e;
            8'h0c: inv_sbox = 8'h81;
            8'h0d: inv_sbox = 8'hf3;
            8'h0e: inv_sbox = 8'hd7;
            8'h0f: inv_sbox = 8'hfb;
            8'h10: inv_sbox = 8'h7c;
            8'h11: inv_sbox = 8'he3;
            8'h12: inv_sbox = 8'h39;
            8'h13: inv_sbox = 8'h82;
            8'h14: inv_sbox = 8'h9b;
            8'h15: inv_sbox = 8'h2f;
            8'h16: inv_sbox = 8'hff;
            8'h17: inv_sbox = 8'h87;
            8'h18: inv_sbox = 8'h34;
            8'h19: inv_sbox = 8'h8e;
            8'h1a: inv_sbox = 8'h43;
            8'h1b: inv_sbox = 8'h44;
            8'h1c: inv_sbox = 8'hc4;
            8'h1d: inv_sbox = 8'hde;
            8'h1e: inv_sbox = 8'he9;
            8'h1f: inv_sbox = 8'hcb;
            8'h20: inv_sbox = 8'h54;
            8'h21: inv_sbox = 8'h7b;
            8'h22: inv_sbox = 8'h94;
            8'h23: inv_sbox = 8'h32;
            8'h24: inv_sbox = 8'ha6;
            8'h25: inv_sbox = 8'hc2;
            8'h26: inv_sbox = 8'h23;
            8'h27: inv_sbox = 8'h3d;
            8'h28: inv_sbox = 8'hee;
            8'h29: inv_sbox = 8'h4c;
            8'h2a: inv_sbox = 8'h95;
            8'h2b: inv_sbox = 8'h0b;
            8'h2c: inv_sbox = 8'h42;
            8'h2d: inv_sbox = 8'hfa;
            8'h2e: inv_sbox = 8'hc3;
            8'h2f: inv_sbox = 8'h4e;
            8'h30: inv_sbox = 8'h08;
            8'h31: inv_sbox = 8'h2e;
            8'h32: inv_sbox = 8'ha1;
            8'h33: inv_sbox = 8'h66;
            8'h34: inv_sbox = 8'h28;
            8'h35: inv_sbox = 8'hd9;
            8'h36: inv_sbox = 8'h24;
            8'h37: inv_sbox = 8'hb2;
            8'h38: inv_sbox = 8'h76;
            8'h39: inv_sbox = 8'h5b;
            8'h3a: inv_sbox = 8'ha2;
            8'h3b: inv_sbox = 8'h49;
            8'h3c: inv_sbox = 8'h6d;
            8'h3d: inv_sbox = 8'h8b;
            8'h3e: inv_sbox = 8'hd1;
            8'h3f: inv_sbox = 8'h25;
            8'h40: inv_sbox = 8'h72;
            8'h41: inv_sbox = 8'hf8;
            8'h42: inv_sbox = 8'hf6;
            8'h43: inv_sbox = 8'h64;
            8'h44: inv_sbox = 8'h86;
            8'h45: inv_sbox = 8'h68;
            8'h46: inv_sbox = 8'h98;
            8'h47: inv_sbox = 8'h16;
            8'h48: inv_sbox = 8'hd4;
            8'h49: inv_sbox = 8'ha4;
            8'h4a: inv_sbox = 8'h5c;
            8'h4b: inv_sbox = 8'hcc;
            8'h4c: inv_sbox = 8'h5d;
            8'h4d: inv_sbox = 8'h65;
            8'h4e: inv_sbox = 8'hb6;
            8'h4f: inv_sbox = 8'h92;
            8'h50: inv_sbox = 8'h6c;
            8'h51: inv_sbox = 8'h70;
            8'h52: inv_sbox = 8'h48;
            8'h53: inv_sbox = 8'h50;
            8'h54: inv_sbox = 8'hfd;
            8'h55: inv_sbox = 8'hed;
            8'h56: inv_sbox = 8'hb9;
            8'h57: inv_sbox = 8'hda;
            8'h58: inv_sbox = 8'h5e;
            8'h59: inv_sbox = 8'h15;
            8'h5a: inv_sbox = 8'h46;
            8'h5b: inv_sbox = 8'h57;
            8'h5c: inv_sbox = 8'ha7;
            8'h5d: inv_sbox = 8'h8d;
            8'h5e: inv_sbox = 8'h9d;
            8'h5f: inv_sbox = 8'h84;
            8'h60: inv_sbox = 8'h90;
            8'h61: inv_sbox = 8'hd8;
            8'h62: inv_sbox = 8'hab;
            8'h63: inv_sbox = 8'h00;
            8'h64: inv_sbox = 8'h8c;
            8'h65: inv_sbox = 8'hbc;
            8'h66: inv_sbox = 8'hd3;
            8'h67: inv_sbox = 8'h0a;
            8'h68: inv_sbox = 8'hf7;
            8'h69: inv_sbox = 8'he4;
            8'h6a: inv_sbox = 8'h58;
            8'h6b: inv_sbox = 8'h05;
            8'h6c: inv_sbox = 8'hb8;
            8'h6d: inv_sbox = 8'hb3;
            8'h6e: inv_sbox = 8'h45;
            8'h6f: inv_sbox = 8'h06;
            8'h70: inv_sbox = 8'hd0;
            8'h71: inv_sbox = 8'h2c;
            8'h72: inv_sbox = 8'h1e;
            8'h73: inv_sbox = 8'h8f;
            8'h74: inv_sbox = 8'hca;
            8'h75: inv_sbox = 8'h3f;
            8'h76: inv_sbox = 8'h0f;
            8'h77: inv_sbox = 8'h02;
            8'h78: inv_sbox = 8'hc1;
            8'h79: inv_sbox = 8'haf;
            8'h7a: inv_sbox = 8'hbd;
            8'h7b: inv_sbox = 8'h03;
            8'h7c: inv_sbox = 8'h01;
            8'h7d: inv_sbox = 8'h13;
            8'h7e: inv_sbox = 8'h8a;
            8'h7f: inv_sbox = 8'h6b;
            8'h80: inv_sbox = 8'h3a;
            8'h81: inv_sbox = 8'h91;
            8'h82: inv_sbox = 8'h11;
            8'h83: inv_sbox = 8'h41;
            8'h84: inv_sbox = 8'h4f;
            8'h85: inv_sbox = 8'h67;
            8'h86: inv_sbox = 8'hdc;
            8'h87: inv_sbox = 8'hea;
            8'h88: inv_sbox = 8'h97;
            8'h89: inv_sbox = 8'hf2;
            8'h8a: inv_sbox = 8'hcf;
            8'h8b: inv_sbox = 8'hce;
            8'h8c: inv_sbox = 8'hf0;
            8'h8d: inv_sbox = 8'hb4;
            8'h8e: inv_sbox = 8'he6;
            8'h8f: inv_sbox = 8'h73;
            8'h90: inv_sbox = 8'h96;
            8'h91: inv_sbox = 8'hac;
            8'h92: inv_sbox = 8'h74;
            8'h93: inv_sbox = 8'h22;
            8'h94: inv_sbox = 8'he7;
            8'h95: inv_sbox = 8'had;
            8'h96: inv_sbox = 8'h35;
            8'h97: inv_sbox = 8'h85;
            8'h98: inv_sbox = 8'he2;
            8'h99: inv_sbox = 8'hf9;
            8'h9a: inv_sbox = 8'h37;
            8'h9b: inv_sbox = 8'he8;
            8'h9c: inv_sbox = 8'h1c;
            8'h9d: inv_sbox = 8'h75;
            8'h9e: inv_sbox = 8'hdf;
            8'h9f: inv_sbox = 8'h6e;
            8'ha0: inv_sbox = 8'h47;
            8'ha1: inv_sbox = 8'hf1;
            8'ha2: inv_sbox = 8'h1a;
            8'ha3: inv_sbox = 8'h71;
            8'ha4: inv_sbox = 8'h1d;
            8'ha5: inv_sbox = 8'h29;
            8'ha6: inv_sbox = 8'hc5;
            8'ha7: inv_sbox = 8'h89;
            8'ha8: inv_sbox = 8'h6f;
            8'ha9: inv_sbox = 8'hb7;
            8'haa: inv_sbox = 8'h62;
            8'hab: inv_sbox = 8'h0e;
            8'hac: inv_sbox = 8'haa;
            8'had: inv_sbox = 8'h18;
            8'hae: inv_sbox = 8'hbe;
            8'haf: inv_sbox = 8'h1b;
            8'hb0: inv_sbox = 8'hfc;
            8'hb1: inv_sbox = 8'h56;
            8'hb2: inv_sbox = 8'h3e;
            8'hb3: inv_sbox = 8'h4b;
            8'hb4: inv_sbox = 8'hc6;
            8'hb5: inv_sbox = 8'hd2;
            8'hb6: inv_sbox = 8'h79;
            8'hb7: inv_sbox = 8'h20;
            8'hb8: inv_sbox = 8'h9a;
            8'hb9: inv_sbox = 8'hdb;
            8'hba: inv_sbox = 8'hc0;
            8'hbb: inv_sbox = 8'hfe;
            8'hbc: inv_sbox = 8'h78;
            8'hbd: inv_sbox = 8'hcd;
            8'hbe: inv_sbox = 8'h5a;
            8'hbf: inv_sbox = 8'hf4;
            8'hc0: inv_sbox = 8'h1f;
            8'hc1: inv_sbox = 8'hdd;
            8'hc2: inv_sbox = 8'ha8;
            8'hc3: inv_sbox = 8'h33;
            8'hc4: inv_sbox = 8'h88;
            8'hc5: inv_sbox = 8'h07;
            8'hc6: inv_sbox = 8'hc7;
            8'hc7: inv_sbox = 8'h31;
            8'hc8: inv_sbox = 8'hb1;
            8'hc9: inv_sbox = 8'h12;
            8'hca: inv_sbox = 8'h10;
            8'hcb: inv_sbox = 8'h59;
            8'hcc: inv_sbox = 8'h27;
            8'hcd: inv_sbox = 8'h80;
            8'hce: inv_sbox = 8'hec;
            8'hcf: inv_sbox = 8'h5f;
            8'hd0: inv_sbox = 8'h60;
            8'hd1: inv_sbox = 8'h51;
            8'hd2: inv_sbox = 8'h7f;
            8'hd3: inv_sbox = 8'ha9;
            8'hd4: inv_sbox = 8'h19;
            8'hd5: inv_sbox = 8'hb5;
            8'hd6: inv_sbox = 8'h4a;
            8'hd7: inv_sbox = 8'h0d;
            8'hd8: inv_sbox = 8'h2d;
            8'hd9: inv_sbox = 8'he5;
            8'hda: inv_sbox = 8'h7a;
            8'hdb: inv_sbox = 8'h9f;
            8'hdc: inv_sbox = 8'h93;
            8'hdd: inv_sbox = 8'hc9;
            8'hde: inv_sbox = 8'h9c;
            8'hdf: inv_sbox = 8'hef;
            8'he0: inv_sbox = 8'ha0;
            8'he1: inv_sbox = 8'he0;
            8'he2: inv_sbox = 8'h3b;
            8'he3: inv_sbox = 8'h4d;
            8'he4: inv_sbox = 8'hae;
            8'he5: inv_sbox = 8'h2a;
            8'he6: inv_sbox = 8'hf5;
            8'he7: inv_sbox = 8'hb0;
            8'he8: inv_sbox = 8'hc8;
            8'he9: inv_sbox = 8'heb;
            8'hea: inv_sbox = 8'hbb;
            8'heb: inv_sbox = 8'h3c;
            8'hec: inv_sbox = 8'h83;
            8'hed: inv_sbox = 8'h53;
            8'hee: inv_sbox = 8'h99;
            8'hef: inv_sbox = 8'h61;
            8'hf0: inv_sbox = 8'h17;
            8'hf1: inv_sbox = 8'h2b;
            8'hf2: inv_sbox = 8'h04;
            8'hf3: inv_sbox = 8'h7e;
            8'hf4: inv_sbox = 8'hba;
            8'hf5: inv_sbox = 8'h77;
            8'hf6: inv_sbox = 8'hd6;
            8'hf7: inv_sbox = 8'h26;
            8'hf8: inv_sbox = 8'he1;
            8'hf9: inv_sbox = 8'h69;
            8'hfa: inv_sbox = 8'h14;
            8'hfb: inv_sbox = 8'h63;
            8'hfc: inv_sbox = 8'h55;
            8'hfd: inv_sbox = 8'h21;
            8'hfe: inv_sbox = 8'h0c;
            8'hff: inv_sbox = 8'h7d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            work_q     <= 128'h0;
            data_out_q <= 128'h0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
        end
    end

    // On the final lane, data_out takes work_d so it already contains that lane's result
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        data_out_d = data_out_q;
        ready_d    = ready_q;
`ifdef INV_SUB_BYTES_QUAD_EN
        lane_word  = work_q[{cnt_q[3:2], 5'b00000} +: 32];
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = data_in;
                    cnt_d   = 4'd0;
                    ready_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef INV_SUB_BYTES_QUAD_EN
                work_d[{cnt_q[3:2], 5'b00000} +: 32] = {inv_sbox(lane_word[31:24]),
                                                        inv_sbox(lane_word[23:16]),
                                                        inv_sbox(lane_word[15:8]),
                                                        inv_sbox(lane_word[7:0])};
`else
                work_d[{cnt_q, 3'b000} +: 8] = inv_sbox(work_q[{cnt_q, 3'b000} +: 8]);
`endif
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == LAST_CNT) begin
                    data_out_d = work_d;
                    ready_d    = 1'b1;
                    state_d    = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;
    assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Self-checking bench for inv_sub_bytes; reference inverse S-box derived from GF(2^8) math.
// Honours INV_SUB_BYTES_QUAD_EN for the expected latency.
module tb_inv_sub_bytes;

`ifdef INV_SUB_BYTES_QUAD_EN
    localparam int LAT      = 4;
    localparam int PULSE_AT = 2;
    localparam int MID_RST  = 2;
`else
    localparam int LAT      = 16;
    localparam int PULSE_AT = 5;
    localparam int MID_RST  = 8;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic [127:0] data_out;
    logic         ready;
    logic         busy;

    int           total;
    int           bad;
    logic [7:0]   inv_tab [256];
    logic [127:0] prev_out;

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [6];

    inv_sub_bytes dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Forward S-box from multiplicative inverse plus affine map
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] put_byte(input logic [127:0] base, input int lane,
                                              input logic [7:0] val);
        logic [127:0] r;
        r = base;
        r[8*lane +: 8] = val;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] din);
        data_in = din;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Start a run, then check every edge up to completion; optional stray start at edge pulse_at
    task automatic run_check(input logic [127:0] din, input logic [127:0] exp,
                             input int pulse_at, input string tag);
        applyStimulus(din);
        checkOutput({tag, "/e0_busy"}, {127'h0, busy}, 128'h1);
        checkOutput({tag, "/e0_ready"}, {127'h0, ready}, 128'h0);
        checkOutput({tag, "/e0_out"}, data_out, prev_out);
        for (int k = 1; k <= LAT; k++) begin
            if (k == pulse_at) begin
                start   = 1'b1;
                data_in = ~din;
            end
            @(posedge clk);
            #1;
            if (k == pulse_at) start = 1'b0;
            if (k < LAT) begin
                checkOutput($sformatf("%s/e%0d_busy", tag, k), {127'h0, busy}, 128'h1);
                checkOutput($sformatf("%s/e%0d_ready", tag, k), {127'h0, ready}, 128'h0);
                checkOutput($sformatf("%s/e%0d_out", tag, k), data_out, prev_out);
            end else begin
                checkOutput({tag, "/done_busy"}, {127'h0, busy}, 128'h0);
                checkOutput({tag, "/done_ready"}, {127'h0, ready}, 128'h1);
                checkOutput({tag, "/done_out"}, data_out, exp);
            end
        end
        prev_out = exp;
    endtask

    initial begin
        logic [7:0]   vals [256];
        logic [7:0]   tmp;
        logic [127:0] din;
        int           j;

        total    = 0;
        bad      = 0;
        prev_out = 128'h0;
        rst      = 1'b0;
        start    = 1'b0;
        data_in  = 128'h0;

        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

        vecs[0].din = {16{8'h63}};
        vecs[0].exp = 128'h0;
        vecs[1].din = {{15{8'h52}}, 8'hED};
        vecs[1].exp = {{15{8'h48}}, 8'h53};
        vecs[2].din = put_byte({16{8'h63}}, 3, 8'h7C);
        vecs[2].exp = put_byte(128'h0, 3, 8'h01);
        vecs[3].din = put_byte({16{8'h63}}, 7, 8'h16);
        vecs[3].exp = put_byte(128'h0, 7, 8'hFF);
        vecs[4].din = put_byte({16{8'h63}}, 12, 8'h00);
        vecs[4].exp = put_byte(128'h0, 12, 8'h52);
        vecs[5].din = put_byte({16{8'h63}}, 15, 8'h8C);
        vecs[5].exp = put_byte(128'h0, 15, 8'hF0);

        #2;
        checkOutput("reset_busy", {127'h0, busy}, 128'h0);
        checkOutput("reset_ready", {127'h0, ready}, 128'h0);
        checkOutput("reset_out", data_out, 128'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_check(vecs[i].din, vecs[i].exp, 0, $sformatf("vec%0d", i));
            repeat (2) @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_hold", i), data_out, vecs[i].exp);
        end

        // All 256 byte values, shuffled across 16 runs
        for (int i = 0; i < 256; i++) vals[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j       = int'($urandom_range(i, 0));
            tmp     = vals[i];
            vals[i] = vals[j];
            vals[j] = tmp;
        end
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 16; k++) din[8*k +: 8] = vals[16*r + k];
            run_check(din, model(din), 0, $sformatf("sweep%0d", r));
        end

        for (int r = 0; r < 4; r++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            run_check(din, model(din), 0, $sformatf("rand%0d", r));
        end

        // Stray start mid-run is ignored; then restart straight out of DONE
        din = {$urandom, $urandom, $urandom, $urandom};
        run_check(din, model(din), PULSE_AT, "stray_start");
        din = {$urandom, $urandom, $urandom, $urandom};
        run_check(din, model(din), 0, "b2b");

        // Asynchronous reset in the middle of a run
        din = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(din);
        repeat (MID_RST - 1) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy", {127'h0, busy}, 128'h0);
        checkOutput("midrst_ready", {127'h0, ready}, 128'h0);
        checkOutput("midrst_out", data_out, 128'h0);
        prev_out = 128'h0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("post_rst%0d_busy", k), {127'h0, busy}, 128'h0);
            checkOutput($sformatf("post_rst%0d_out", k), data_out, 128'h0);
        end
        run_check(vecs[1].din, vecs[1].exp, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
